// File: rtl/uart_rx_start_detect.sv
// Start-bit qualifier for the UART receiver: synchronises RX_IN, arms on an idle-line
// falling edge, majority-votes mid-bit samples and reports valid starts or glitches.
module uart_rx_start_detect #(
  parameter int SYNC_STAGES  = 2,
  parameter int PRESC_W      = 6,
  parameter int VOTE_SAMPLES = 3,
  parameter int GCNT_W       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               Enable,
  input  logic               Frame_busy,
  input  logic               clear_cnt,
  output logic               strt_valid,
  output logic               strt_glitch,
  output logic               detecting,
  output logic [GCNT_W-1:0]  glitch_cnt
);

  localparam int H  = (VOTE_SAMPLES - 1) / 2;
  localparam int VW = $clog2(VOTE_SAMPLES + 1) + 1;
  localparam logic [PRESC_W-1:0] P_MIN    = PRESC_W'(4);
  localparam logic [PRESC_W-1:0] HALF_WIN = PRESC_W'(H);
  localparam logic [VW-1:0]      NEED     = VW'(H + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                r_prev;
  logic                w_rx_s, w_fall;
  logic [PRESC_W-1:0]  r_presc, w_presc_nxt, w_presc_eff;
  logic [PRESC_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PRESC_W-1:0]  w_mid, w_lo, w_hi, w_last;
  logic [VW-1:0]       r_votes, w_votes_nxt, w_zeros;
  logic                w_in_win, w_vote_ok;
  logic                w_valid_nxt, w_glitch_nxt;
  logic                r_valid, r_glitch, r_detect;
  logic [GCNT_W-1:0]   r_gcnt;

  // Line idles high, so the synchroniser and edge history reset to 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
      r_prev <= w_rx_s;
    end
  end

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_fall      = r_prev & ~w_rx_s;
  assign w_presc_eff = (Prescale < P_MIN) ? P_MIN : {Prescale[PRESC_W-1:1], 1'b0};
  assign w_mid       = r_presc >> 1;
  assign w_lo        = w_mid - HALF_WIN;
  assign w_hi        = w_mid + HALF_WIN;
  assign w_last      = r_presc - PRESC_W'(1);
  assign w_in_win    = (r_cnt >= w_lo) && (r_cnt <= w_hi);
  assign w_zeros     = r_votes + {{(VW-1){1'b0}}, ~w_rx_s};
  assign w_vote_ok   = (w_zeros >= NEED);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_votes_nxt  = '0;
    w_presc_nxt  = r_presc;
    w_valid_nxt  = 1'b0;
    w_glitch_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && Enable && !Frame_busy) begin
          w_state_nxt = S_CHECK;
          w_cnt_nxt   = PRESC_W'(1);
          w_presc_nxt = w_presc_eff;
        end
      end
      S_CHECK: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + PRESC_W'(1);
          w_votes_nxt = w_in_win ? w_zeros : r_votes;
          if (r_cnt == w_hi) begin
            // With the smallest prescale the vote lands on the last tick of the bit.
            if (!w_vote_ok) begin
              w_state_nxt  = S_IDLE;
              w_glitch_nxt = 1'b1;
              w_cnt_nxt    = '0;
              w_votes_nxt  = '0;
            end else if (r_cnt == w_last) begin
              w_state_nxt = S_IDLE;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_votes_nxt = '0;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == w_last) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + PRESC_W'(1);
          w_votes_nxt = r_votes;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_votes  <= '0;
      r_presc  <= P_MIN;
      r_valid  <= 1'b0;
      r_glitch <= 1'b0;
      r_detect <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_votes  <= w_votes_nxt;
      r_presc  <= w_presc_nxt;
      r_valid  <= w_valid_nxt;
      r_glitch <= w_glitch_nxt;
      r_detect <= (w_state_nxt != S_IDLE);
    end
  end

  // Counts visible glitch pulses; a clear in the same cycle wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gcnt <= '0;
    end else if (clear_cnt) begin
      r_gcnt <= '0;
    end else if (r_glitch && (r_gcnt != '1)) begin
      r_gcnt <= r_gcnt + GCNT_W'(1);
    end
  end

  assign strt_valid  = r_valid;
  assign strt_glitch = r_glitch;
  assign detecting   = r_detect;
  assign glitch_cnt  = r_gcnt;

endmodule

// File: tb/tb_uart_rx_start_detect.sv
// Self-checking bench for uart_rx_start_detect: per-cycle stimulus tables are played
// into the DUT and compared against a trace-level model of start-bit qualification.
module tb_uart_rx_start_detect;

  localparam int SYNC  = 2;
  localparam int PW    = 6;
  localparam int VOTES = 3;
  localparam int GW    = 8;
  localparam int HW    = (VOTES - 1) / 2;
  localparam int GMAX  = (1 << GW) - 1;
  localparam int MAXN  = 2400;
  localparam int TAIL  = 72;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          Enable;
  logic          Frame_busy;
  logic          clear_cnt;
  logic          strt_valid;
  logic          strt_glitch;
  logic          detecting;
  logic [GW-1:0] glitch_cnt;

  uart_rx_start_detect #(
    .SYNC_STAGES (SYNC),
    .PRESC_W     (PW),
    .VOTE_SAMPLES(VOTES),
    .GCNT_W      (GW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .Enable     (Enable),
    .Frame_busy (Frame_busy),
    .clear_cnt  (clear_cnt),
    .strt_valid (strt_valid),
    .strt_glitch(strt_glitch),
    .detecting  (detecting),
    .glitch_cnt (glitch_cnt)
  );

  always #5 CLK = ~CLK;

  // Stimulus per period, DUT observations per period, and model expectations.
  bit            sRx[MAXN];
  bit            sEn[MAXN];
  bit            sBusy[MAXN];
  bit            sClr[MAXN];
  int            sPre[MAXN];
  logic          oValid[MAXN];
  logic          oGlitch[MAXN];
  logic          oDet[MAXN];
  logic [GW-1:0] oCnt[MAXN];
  int            eValid[MAXN];
  int            eGlitch[MAXN];
  int            eDet[MAXN];
  int            eCnt[MAXN];

  int checks   = 0;
  int errors   = 0;
  int modelCnt = 0;

  task automatic checkOutput(input string tag, input int idx,
                             input logic [31:0] obsV, input logic [31:0] expV);
    checks++;
    assert (obsV === expV) else begin
      errors++;
      $error("[TB] FAIL %s @%0d observed=%0d expected=%0d", tag, idx, obsV, expV);
    end
  endtask

  task automatic clearSeg(input int n, input int pre);
    for (int i = 0; i < n; i++) begin
      sRx[i]   = 1'b1;
      sEn[i]   = 1'b1;
      sBusy[i] = 1'b0;
      sClr[i]  = 1'b0;
      sPre[i]  = pre;
    end
  endtask

  // Each period: observe registered outputs at the falling edge, then drive inputs.
  task automatic applyStimulus(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      oValid[j]  = strt_valid;
      oGlitch[j] = strt_glitch;
      oDet[j]    = detecting;
      oCnt[j]    = glitch_cnt;
      RX_IN      = sRx[j];
      Enable     = sEn[j];
      Frame_busy = sBusy[j];
      clear_cnt  = sClr[j];
      Prescale   = PW'(sPre[j]);
    end
  endtask

  function automatic int effP(input int v);
    if (v < 4) return 4;
    return (v / 2) * 2;
  endfunction

  // Synchronised line as seen by the detector: RX_IN delayed by SYNC periods.
  function automatic bit rxs(input int j, input int n);
    int idx;
    idx = j - SYNC;
    if (idx < 0 || idx >= n) return 1'b1;
    return sRx[idx];
  endfunction

  task automatic modelCompare(input int n, input string tag);
    int t;
    int c;
    for (int i = 0; i < n; i++) begin
      eValid[i]  = 0;
      eGlitch[i] = 0;
      eDet[i]    = 0;
    end
    t = 0;
    while (t < n) begin
      if (rxs(t - 1, n) && !rxs(t, n) && sEn[t] && !sBusy[t]) begin
        int p, mid, zeros, fin, abortAt;
        bit ok;
        p     = effP(sPre[t]);
        mid   = p / 2;
        zeros = 0;
        for (int k = mid - HW; k <= mid + HW; k++)
          if (!rxs(t + k, n)) zeros++;
        ok      = (zeros >= HW + 1);
        fin     = ok ? t + p : t + mid + HW + 1;
        abortAt = -1;
        for (int k = t + 1; k < fin; k++)
          if (k < n && !sEn[k] && abortAt < 0) abortAt = k;
        if (abortAt >= 0) fin = abortAt + 1;
        else if (fin < n && ok) eValid[fin] = 1;
        else if (fin < n) eGlitch[fin] = 1;
        for (int k = t + 1; k < fin && k < n; k++) eDet[k] = 1;
        t = fin;
      end else begin
        t++;
      end
    end
    c = modelCnt;
    for (int j = 0; j < n; j++) begin
      eCnt[j] = c;
      if (sClr[j]) c = 0;
      else if (eGlitch[j] != 0 && c < GMAX) c = c + 1;
    end
    modelCnt = c;
    for (int j = 0; j < n; j++) begin
      checkOutput({tag, ".valid"},  j, 32'(oValid[j]),  32'(eValid[j]));
      checkOutput({tag, ".glitch"}, j, 32'(oGlitch[j]), 32'(eGlitch[j]));
      checkOutput({tag, ".detect"}, j, 32'(oDet[j]),    32'(eDet[j]));
      checkOutput({tag, ".cnt"},    j, 32'(oCnt[j]),    32'(eCnt[j]));
    end
  endtask

  task automatic countPulses(input int n, output int nv, output int ng, output int nd);
    nv = 0; ng = 0; nd = 0;
    for (int j = 0; j < n; j++) begin
      if (oValid[j] === 1'b1)  nv++;
      if (oGlitch[j] === 1'b1) ng++;
      if (oDet[j] === 1'b1)    nd++;
    end
  endtask

  task automatic genRandom(input int n);
    int j, pre, len;
    bit lvl;
    clearSeg(n, $urandom_range(0, 63));
    j   = 0;
    lvl = 1'b0;
    pre = sPre[0];
    while (j < n - TAIL) begin
      if ($urandom_range(0, 9) == 0) pre = $urandom_range(0, 63);
      len = lvl ? $urandom_range(1, 14) : $urandom_range(1, effP(pre) + 3);
      for (int k = 0; k < len && j < n - TAIL; k++) begin
        sRx[j]  = lvl;
        sPre[j] = pre;
        j++;
      end
      lvl = !lvl;
    end
    for (int i = 0; i < n - TAIL; i++) begin
      if ($urandom_range(0, 39) == 0) sEn[i] = 1'b0;
      if ($urandom_range(0, 29) == 0)
        for (int k = i; k < i + 4 && k < n - TAIL; k++) sBusy[k] = 1'b1;
      if ($urandom_range(0, 59) == 0) sClr[i] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nv, ng, nd, n;
    RST        = 1'b1;
    RX_IN      = 1'b1;
    Enable     = 1'b1;
    Frame_busy = 1'b0;
    clear_cnt  = 1'b0;
    Prescale   = PW'(8);
    repeat (3) @(negedge CLK);
    checkOutput("reset.valid",  0, 32'(strt_valid),  0);
    checkOutput("reset.glitch", 0, 32'(strt_glitch), 0);
    checkOutput("reset.detect", 0, 32'(detecting),   0);
    checkOutput("reset.cnt",    0, 32'(glitch_cnt),  0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Valid start with P=8; a mid-attempt Prescale change must be ignored.
    clearSeg(80, 8);
    for (int i = 5; i <= 12; i++) sRx[i] = 1'b0;
    for (int i = 9; i < 80; i++) sPre[i] = 32;
    applyStimulus(80);
    modelCompare(80, "t1");
    countPulses(80, nv, ng, nd);
    checkOutput("t1.validAtT8", 15, 32'(oValid[15]), 1);
    checkOutput("t1.nValid",    0, nv, 1);
    checkOutput("t1.nGlitch",   0, ng, 0);
    checkOutput("t1.cntEnd",    79, 32'(oCnt[79]), 0);

    // Short low pulse rejected as a glitch.
    clearSeg(60, 8);
    sRx[5] = 1'b0; sRx[6] = 1'b0;
    applyStimulus(60);
    modelCompare(60, "t2");
    countPulses(60, nv, ng, nd);
    checkOutput("t2.glitchAtT6", 13, 32'(oGlitch[13]), 1);
    checkOutput("t2.detBefore",  12, 32'(oDet[12]), 1);
    checkOutput("t2.detAtT6",    13, 32'(oDet[13]), 0);
    checkOutput("t2.nValid",     0, nv, 0);
    checkOutput("t2.cnt",        20, 32'(oCnt[20]), 1);

    // Vote patterns 0,1,0 (accept) and 1,0,1 (reject).
    clearSeg(60, 8);
    for (int i = 5; i <= 8; i++) sRx[i] = 1'b0;
    sRx[10] = 1'b0;
    applyStimulus(60);
    modelCompare(60, "t3a");
    checkOutput("t3a.validAtT8", 15, 32'(oValid[15]), 1);
    clearSeg(60, 8);
    sRx[5] = 1'b0; sRx[9] = 1'b0;
    applyStimulus(60);
    modelCompare(60, "t3b");
    checkOutput("t3b.glitchAtT6", 13, 32'(oGlitch[13]), 1);
    checkOutput("t3b.cnt",        59, 32'(oCnt[59]), 2);

    // Frame_busy masks the edge; the still-low line must not retrigger later.
    clearSeg(80, 8);
    for (int i = 0; i <= 14; i++) sBusy[i] = 1'b1;
    for (int i = 5; i <= 40; i++) sRx[i] = 1'b0;
    applyStimulus(80);
    modelCompare(80, "t4a");
    countPulses(80, nv, ng, nd);
    checkOutput("t4a.nDetect", 0, nd, 0);
    checkOutput("t4a.nValid",  0, nv, 0);
    checkOutput("t4a.nGlitch", 0, ng, 0);

    // Enable dropped at tick 5 of a valid start; line stays low afterwards.
    clearSeg(100, 8);
    for (int i = 5; i <= 60; i++) sRx[i] = 1'b0;
    sEn[12] = 1'b0;
    applyStimulus(100);
    modelCompare(100, "t4b");
    countPulses(100, nv, ng, nd);
    checkOutput("t4b.detTick5", 12, 32'(oDet[12]), 1);
    checkOutput("t4b.detAfter", 13, 32'(oDet[13]), 0);
    checkOutput("t4b.nDetect",  0, nd, 5);
    checkOutput("t4b.nValid",   0, nv, 0);
    checkOutput("t4b.nGlitch",  0, ng, 0);

    // Prescale 3 clamps to 4, then Prescale 32.
    clearSeg(60, 3);
    for (int i = 5; i <= 8; i++) sRx[i] = 1'b0;
    applyStimulus(60);
    modelCompare(60, "t6a");
    countPulses(60, nv, ng, nd);
    checkOutput("t6a.validAtT4", 11, 32'(oValid[11]), 1);
    checkOutput("t6a.nValid",    0, nv, 1);
    clearSeg(120, 32);
    for (int i = 5; i <= 36; i++) sRx[i] = 1'b0;
    applyStimulus(120);
    modelCompare(120, "t6b");
    countPulses(120, nv, ng, nd);
    checkOutput("t6b.validAtT32", 39, 32'(oValid[39]), 1);
    checkOutput("t6b.nValid",     0, nv, 1);

    // 257 glitches saturate the 8-bit counter.
    n = 5 + 8 * 257 + TAIL;
    clearSeg(n, 8);
    for (int g = 0; g < 257; g++) begin
      sRx[5 + 8 * g] = 1'b0;
      sRx[6 + 8 * g] = 1'b0;
    end
    applyStimulus(n);
    modelCompare(n, "t5");
    countPulses(n, nv, ng, nd);
    checkOutput("t5.nGlitch", 0, ng, 257);
    checkOutput("t5.cntSat",  n - 1, 32'(oCnt[n-1]), GMAX);

    // Asynchronous reset in the middle of CHECK.
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (SYNC + 3) @(negedge CLK);
    checkOutput("rst.detBefore", 0, 32'(detecting), 1);
    #2 RST = 1'b1;
    #1;
    checkOutput("rst.valid",  0, 32'(strt_valid),  0);
    checkOutput("rst.glitch", 0, 32'(strt_glitch), 0);
    checkOutput("rst.detect", 0, 32'(detecting),   0);
    checkOutput("rst.cnt",    0, 32'(glitch_cnt),  0);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    modelCnt = 0;
    repeat (6) @(negedge CLK);

    // clear_cnt coinciding with a glitch pulse wins over the increment.
    clearSeg(80, 8);
    sRx[5] = 1'b0; sRx[6] = 1'b0;
    sRx[25] = 1'b0; sRx[26] = 1'b0;
    sClr[33] = 1'b1;
    applyStimulus(80);
    modelCompare(80, "t5b");
    checkOutput("t5b.cntOne",      20, 32'(oCnt[20]), 1);
    checkOutput("t5b.glitchClr",   33, 32'(oGlitch[33]), 1);
    checkOutput("t5b.cntCleared",  34, 32'(oCnt[34]), 0);

    // Randomised line activity, Enable/Frame_busy/clear/Prescale disturbances.
    for (int s = 0; s < 5; s++) begin
      genRandom(500);
      applyStimulus(500);
      modelCompare(500, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
